// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache. It sits between the CPU fetch
// stage and a 1024-byte instruction memory. It holds 8 lines, and each line
// is one 16-byte block.
//
// A hit returns the addressed 32-bit word combinationally, in the same cycle
// the address is presented. On a miss the cache does the following:
//   1. Stalls the CPU with busywait.
//   2. Fetches the whole 128-bit block using the memory read/busywait
//      handshake.
//   3. Installs the block in the indexed line.
//   4. Serves the still-held fetch as a hit.
//
// Ports
//   clock         in   1    CPU clock, rising-edge active
//   reset_n       in   1    asynchronous active-low reset
//   read          in   1    CPU fetch request
//   address       in   10   byte PC: tag [9:7], index [6:4], word [3:2]
//   instruction   out  32   selected word of the indexed line (always driven)
//   busywait      out  1    stall to the CPU
//   mem_read      out  1    block read request to instruction memory
//   mem_address   out  6    block address {tag, index} of the missed fetch
//   mem_readdata  in   128  block from memory, byte i at [8i+7:8i]
//   mem_busywait  in   1    memory busy
// ---------------------------------------------------------------------------
module instruction_cache (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_READ = 2'd1;
  localparam logic [1:0] UPDATE   = 2'd2;

  logic [1:0]   state_r;
  logic [1:0]   state_next_s;
  logic [7:0]   valid_r;
  logic [2:0]   tag_r  [0:7];
  logic [127:0] data_r [0:7];
  logic [5:0]   req_block_r;
  logic         seen_busy_r;

  logic [2:0]   addr_tag_s;
  logic [2:0]   addr_index_s;
  logic [1:0]   addr_word_s;
  logic         hit_s;
  logic [127:0] line_s;
  logic         unused_addr_s;

  assign addr_tag_s   = address[9:7];
  assign addr_index_s = address[6:4];
  assign addr_word_s  = address[3:2];
  // Byte offset within the word is irrelevant for word-aligned fetches.
  assign unused_addr_s = ^address[1:0];

  assign hit_s  = valid_r[addr_index_s] & (tag_r[addr_index_s] == addr_tag_s);
  assign line_s = data_r[addr_index_s];

  // Word select from the indexed line, driven whether or not the access hits.
  always_comb begin
    instruction = 32'd0;
    case (addr_word_s)
      2'd0:    instruction = line_s[31:0];
      2'd1:    instruction = line_s[63:32];
      2'd2:    instruction = line_s[95:64];
      2'd3:    instruction = line_s[127:96];
      default: instruction = 32'd0;
    endcase
  end

  // Handshake outputs and next-state logic for the fill sequencer.
  always_comb begin
    busywait     = 1'b0;
    mem_read     = 1'b0;
    mem_address  = 6'd0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        // The reset_n gate holds the stall low while reset is asserted,
        // even if the CPU is already requesting a fetch.
        busywait = reset_n & read & ~hit_s;
        if (read && !hit_s) begin
          state_next_s = MEM_READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEM_READ: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = req_block_r;
        // A low mem_busywait before memory has ever acknowledged must not
        // end the read; leave only once busy has been seen at least once.
        if (!mem_busywait && seen_busy_r) begin
          state_next_s = UPDATE;
        end else begin
          state_next_s = MEM_READ;
        end
      end
      UPDATE: begin
        busywait     = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, miss capture and busy tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      req_block_r <= 6'd0;
      seen_busy_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          seen_busy_r <= 1'b0;
          if (read && !hit_s) begin
            req_block_r <= address[9:4];
          end
        end
        MEM_READ: begin
          if (mem_busywait) begin
            seen_busy_r <= 1'b1;
          end
        end
        default: begin
          seen_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Line storage: an unconditional install into the line of the captured block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        tag_r[i]  <= 3'd0;
        data_r[i] <= 128'd0;
      end
    end else if (state_r == UPDATE) begin
      valid_r[req_block_r[2:0]] <= 1'b1;
      tag_r[req_block_r[2:0]]   <= req_block_r[5:3];
      data_r[req_block_r[2:0]]  <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a 4-cycle busy memory model.
module tb_instruction_cache;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = 128'd0;
  logic         mem_busywait = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_cnt = 8'd0;

  instruction_cache dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  // Word k of block b is {16'hB000 | b, 16'h000k}.
  function automatic logic [127:0] block_data(input logic [5:0] b);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) begin
      d[32*k +: 32] = {16'hB000 | {10'd0, b}, 16'(k)};
    end
    return d;
  endfunction

  // Memory: the request cycle plus three registered busy cycles, then data is held.
  always @(posedge clock) begin
    if (!mem_read) begin
      mem_cnt      <= 8'd0;
      mem_busywait <= 1'b0;
    end else begin
      mem_cnt <= mem_cnt + 8'd1;
      if (mem_cnt < 8'd3) begin
        mem_busywait <= 1'b1;
      end else begin
        mem_busywait <= 1'b0;
        if (mem_cnt == 8'd3) mem_readdata <= block_data(mem_address);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a fetch and count the stall cycles until busywait drops.
  task automatic fetch(input string tag, input logic [9:0] addr, input logic exp_miss,
                       input logic [5:0] exp_blk, input logic [31:0] exp_instr,
                       input int exp_stall);
    int stall;
    logic seen_mr;
    logic [5:0] mr_addr;
    @(negedge clock);
    read = 1'b1;
    address = addr;
    #1;
    chk({tag, "_busy0"}, {31'd0, busywait}, {31'd0, exp_miss});
    stall = 0;
    seen_mr = 1'b0;
    mr_addr = 6'd0;
    while (busywait && stall < 40) begin
      if (mem_read) begin
        seen_mr = 1'b1;
        mr_addr = mem_address;
      end
      stall++;
      @(negedge clock);
      #1;
    end
    chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, "_instr"}, instruction, exp_instr);
    chk({tag, "_memrd"}, {31'd0, seen_mr}, {31'd0, exp_miss});
    chk({tag, "_maddr"}, {26'd0, mr_addr}, {26'd0, exp_blk});
  endtask

  initial begin
    int n;
    logic [5:0] last_blk;

    // Reset held with a fetch pending: outputs must stay quiet.
    reset_n = 1'b0;
    read = 1'b1;
    address = 10'h000;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_busy",  {31'd0, busywait}, 32'd0);
    chk("rst_memrd", {31'd0, mem_read}, 32'd0);
    chk("rst_maddr", {26'd0, mem_address}, 32'd0);
    chk("rst_instr", instruction, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    read = 1'b0;

    // 1: cold miss on 0x000
    fetch("t1", 10'h000, 1'b1, 6'h00, 32'hB000_0000, 7);
    // 2: same-block hits
    fetch("t2a", 10'h004, 1'b0, 6'h00, 32'hB000_0001, 0);
    fetch("t2b", 10'h008, 1'b0, 6'h00, 32'hB000_0002, 0);
    fetch("t2c", 10'h00C, 1'b0, 6'h00, 32'hB000_0003, 0);
    // 3: conflict on index 0, then refetch of the evicted block
    fetch("t3a", 10'h080, 1'b1, 6'h08, 32'hB008_0000, 7);
    fetch("t3b", 10'h000, 1'b1, 6'h00, 32'hB000_0000, 7);
    // 4: top of the address space
    fetch("t4", 10'h3FC, 1'b1, 6'h3F, 32'hB03F_0003, 7);

    // 5: reset in the second MEM_READ cycle
    @(negedge clock);
    address = 10'h010;
    #1;
    chk("t5_busy0", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    #1;
    chk("t5_memrd1", {31'd0, mem_read}, 32'd1);
    chk("t5_maddr1", {26'd0, mem_address}, 32'h01);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_memrd", {31'd0, mem_read}, 32'd0);
    chk("t5_rst_busy",  {31'd0, busywait}, 32'd0);
    chk("t5_rst_maddr", {26'd0, mem_address}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    read = 1'b0;
    fetch("t5", 10'h010, 1'b1, 6'h01, 32'hB001_0000, 7);

    // 6: address changes mid-fill; the fill of block 2 still completes
    @(negedge clock);
    address = 10'h020;
    #1;
    chk("t6_busy0", {31'd0, busywait}, 32'd1);
    @(negedge clock);
    #1;
    chk("t6_maddr1", {26'd0, mem_address}, 32'h02);
    @(negedge clock);
    address = 10'h000;
    #1;
    chk("t6_memrd2", {31'd0, mem_read}, 32'd1);
    chk("t6_maddr2", {26'd0, mem_address}, 32'h02);
    n = 0;
    last_blk = 6'h3F;
    while (busywait && n < 60) begin
      if (mem_read) last_blk = mem_address;
      n++;
      @(negedge clock);
      #1;
    end
    // Rest of the block-2 fill (5 cycles) plus a full miss on 0x000 (7 cycles).
    chk("t6_cycles", 32'(n), 32'd12);
    chk("t6_lastblk", {26'd0, last_blk}, 32'h00);
    chk("t6_instr0", instruction, 32'hB000_0000);
    fetch("t6_l2", 10'h020, 1'b0, 6'h00, 32'hB002_0000, 0);
    fetch("t6_l1", 10'h014, 1'b0, 6'h00, 32'hB001_0001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
